// File: rtl/arbiter_tx_sched_if.sv
// Bus between the packet scheduler and its word source, key/config memories and units.
// Handshake: a word is offered while word_valid=1 with word_len/ids held stable; it is consumed by the one-cycle word_ready pulse.
interface arbiter_tx_sched_if #(
    parameter int N_UNITS      = 4,
    parameter int WORD_MAX_LEN = 64,
    parameter int CFG_LEN      = 24
);
    localparam int LEN_W = $clog2(WORD_MAX_LEN + 1);
    localparam int RA_W  = $clog2(WORD_MAX_LEN);
    localparam int CA_W  = $clog2(CFG_LEN);

    logic               word_valid;
    logic               word_ready;
    logic [LEN_W-1:0]   word_len;
    logic [63:0]        ids;
    logic [RA_W-1:0]    rd_addr;
    logic [7:0]         din;
    logic [CA_W-1:0]    cfg_addr;
    logic [7:0]         cfg_data;
    logic [7:0]         unit_in;
    logic               unit_in_ctrl;
    logic [N_UNITS-1:0] unit_in_wr_en;
    logic [N_UNITS-1:0] unit_in_afull;
    logic [N_UNITS-1:0] unit_tx_mask;
    logic [N_UNITS-1:0] unit_done;
    logic               bcast_req;
    logic [4:0]         bcast_data;
    logic               bcast_ack;

    modport master (
        input  word_valid, word_len, ids, din, cfg_data,
        input  unit_in_afull, unit_tx_mask, unit_done, bcast_req, bcast_data,
        output word_ready, rd_addr, cfg_addr, unit_in, unit_in_ctrl, unit_in_wr_en, bcast_ack
    );

    modport slave (
        output word_valid, word_len, ids, din, cfg_data,
        output unit_in_afull, unit_tx_mask, unit_done, bcast_req, bcast_data,
        input  word_ready, rd_addr, cfg_addr, unit_in, unit_in_ctrl, unit_in_wr_en, bcast_ack
    );
endinterface

// File: rtl/arbiter_tx_sched.sv
// Round-robin packet scheduler: frames each key word with header/config/ids/length/padding
// and streams it byte-wise to one credit-limited computing unit; also relays broadcast bytes.
module arbiter_tx_sched #(
    parameter int N_UNITS      = 4,
    parameter int WORD_MAX_LEN = 64,
    parameter int CFG_LEN      = 24,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                      CLK,
    input  logic                      rst_n,
    arbiter_tx_sched_if.master        bus,
    output logic                      idle,
    output logic                      err,
    output logic [3:0]                dbg_state
);
    localparam int LEN_W = $clog2(WORD_MAX_LEN + 1);
    localparam int RA_W  = $clog2(WORD_MAX_LEN);
    localparam int CA_W  = $clog2(CFG_LEN);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int UID_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int IDX_W = $clog2(WORD_MAX_LEN + CFG_LEN + 8) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_SEARCH, S_HDR, S_CFG, S_IDS, S_KLEN, S_PAD, S_KEY, S_END, S_BCAST
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx, idx_d, key_last;
    logic [UID_W-1:0]   sel, sel_d, ptr, ptr_d, last, last_d, ptr_next, ptr_start;
    logic [CNT_W-1:0]   cnt [N_UNITS];
    logic [CNT_W-1:0]   cnt_d [N_UNITS];
    logic [7:0]         unit_in_q, byte_d;
    logic               ctrl_q, ctrl_d, ready_q, ready_d, ack_q, ack_d, err_q, err_d;
    logic [N_UNITS-1:0] wr_q, wr_d, sel_oh;
    logic               consume, len_bad, ptr_ok, all_zero;
    logic [LEN_W:0]     key_bytes;

    assign consume   = !bus.unit_in_afull[sel];
    assign len_bad   = (bus.word_len == '0) || (bus.word_len > LEN_W'(WORD_MAX_LEN));
    assign key_bytes = ({1'b0, bus.word_len} + (LEN_W+1)'(3)) & ~((LEN_W+1)'(3));
    assign key_last  = IDX_W'(key_bytes) - IDX_W'(1);
    assign ptr_ok    = !bus.unit_tx_mask[ptr] && (cnt[ptr] < CNT_W'(MAX_INFLIGHT));
    assign ptr_next  = (ptr == UID_W'(N_UNITS - 1)) ? '0 : ptr + UID_W'(1);
    assign ptr_start = (last == UID_W'(N_UNITS - 1)) ? '0 : last + UID_W'(1);

    always_comb begin
        sel_oh      = '0;
        sel_oh[sel] = 1'b1;
    end

    // Addresses run one byte ahead of the byte being registered, but only advance
    // when that byte is actually accepted, so the synchronous memories never skip.
    always_comb begin
        bus.cfg_addr = '0;
        bus.rd_addr  = '0;
        if (state == S_CFG)
            bus.cfg_addr = (consume && idx != IDX_W'(CFG_LEN - 1)) ? CA_W'(idx + IDX_W'(1)) : CA_W'(idx);
        if (state == S_KEY)
            bus.rd_addr = (consume && idx != key_last) ? RA_W'(idx + IDX_W'(1)) : RA_W'(idx);
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        sel_d   = sel;
        ptr_d   = ptr;
        last_d  = last;
        byte_d  = unit_in_q;
        ctrl_d  = 1'b0;
        wr_d    = '0;
        ready_d = 1'b0;
        ack_d   = 1'b0;
        // The registered ready/ack pulse is still visible for one IDLE cycle, so it
        // masks the just-consumed word or broadcast request from being taken twice.
        case (state)
            S_IDLE: begin
                if (bus.bcast_req && !ack_q) begin
                    state_d = S_BCAST;
                end else if (bus.word_valid && !ready_q) begin
                    state_d = S_SEARCH;
                    ptr_d   = ptr_start;
                end
            end
            S_BCAST: begin
                byte_d  = {bus.bcast_data, 3'b001};
                ctrl_d  = 1'b1;
                wr_d    = '1;
                ack_d   = 1'b1;
                state_d = S_IDLE;
            end
            S_SEARCH: begin
                if (len_bad) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else if (ptr_ok) begin
                    sel_d   = ptr;
                    idx_d   = '0;
                    state_d = S_HDR;
                end else begin
                    ptr_d = ptr_next;
                end
            end
            S_HDR: if (consume) begin
                byte_d  = 8'h00;
                ctrl_d  = 1'b1;
                wr_d    = sel_oh;
                idx_d   = '0;
                state_d = S_CFG;
            end
            S_CFG: if (consume) begin
                byte_d = bus.cfg_data;
                wr_d   = sel_oh;
                if (idx == IDX_W'(CFG_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = S_IDS;
                end else idx_d = idx + IDX_W'(1);
            end
            S_IDS: if (consume) begin
                byte_d = bus.ids[{idx[2:0], 3'b000} +: 8];
                wr_d   = sel_oh;
                if (idx == IDX_W'(7)) begin
                    idx_d   = '0;
                    state_d = S_KLEN;
                end else idx_d = idx + IDX_W'(1);
            end
            S_KLEN: if (consume) begin
                byte_d  = 8'(bus.word_len);
                wr_d    = sel_oh;
                idx_d   = '0;
                state_d = S_PAD;
            end
            S_PAD: if (consume) begin
                byte_d = 8'h00;
                wr_d   = sel_oh;
                if (idx == IDX_W'(6)) begin
                    idx_d   = '0;
                    state_d = S_KEY;
                end else idx_d = idx + IDX_W'(1);
            end
            S_KEY: if (consume) begin
                byte_d = bus.din;
                wr_d   = sel_oh;
                if (idx == key_last) begin
                    ctrl_d  = 1'b1;
                    state_d = S_END;
                end else idx_d = idx + IDX_W'(1);
            end
            S_END: begin
                ready_d = 1'b1;
                last_d  = sel;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_d    = err_q;
        all_zero = 1'b1;
        for (int u = 0; u < N_UNITS; u++) begin
            cnt_d[u] = cnt[u];
            if (cnt[u] != '0) all_zero = 1'b0;
            if (bus.unit_done[u] && !(state == S_END && sel == UID_W'(u))) begin
                if (cnt[u] == '0) err_d = 1'b1;
                else cnt_d[u] = cnt[u] - CNT_W'(1);
            end else if (!bus.unit_done[u] && state == S_END && sel == UID_W'(u)) begin
                cnt_d[u] = cnt[u] + CNT_W'(1);
            end
        end
        if (state == S_SEARCH && len_bad) err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            sel       <= '0;
            ptr       <= '0;
            last      <= UID_W'(N_UNITS - 1);
            unit_in_q <= '0;
            ctrl_q    <= 1'b0;
            wr_q      <= '0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            for (int u = 0; u < N_UNITS; u++) cnt[u] <= '0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            sel       <= sel_d;
            ptr       <= ptr_d;
            last      <= last_d;
            unit_in_q <= byte_d;
            ctrl_q    <= ctrl_d;
            wr_q      <= wr_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            for (int u = 0; u < N_UNITS; u++) cnt[u] <= cnt_d[u];
        end
    end

    assign bus.unit_in       = unit_in_q;
    assign bus.unit_in_ctrl  = ctrl_q;
    assign bus.unit_in_wr_en = wr_q;
    assign bus.word_ready    = ready_q;
    assign bus.bcast_ack     = ack_q;
    assign err               = err_q;
    assign idle              = (state == S_IDLE) && !bus.word_valid && all_zero;
    assign dbg_state         = state;
endmodule

// File: tb/tb_arbiter_tx_sched.sv
// Directed bench for arbiter_tx_sched: packet framing, round-robin with credits,
// backpressure, broadcast, error cases and reset mid-packet.
module tb_arbiter_tx_sched;
    localparam int N = 4;
    localparam int WML = 64;
    localparam int CFGL = 24;
    localparam logic [3:0] ST_IDLE = 4'd0, ST_SEARCH = 4'd1, ST_KEY = 4'd7;

    logic clk, rst_n, idle, err;
    logic [3:0] dbg_state;

    arbiter_tx_sched_if #(.N_UNITS(N), .WORD_MAX_LEN(WML), .CFG_LEN(CFGL)) bus ();

    arbiter_tx_sched #(.N_UNITS(N), .WORD_MAX_LEN(WML), .CFG_LEN(CFGL), .MAX_INFLIGHT(1)) dut (
        .CLK(clk), .rst_n(rst_n), .bus(bus), .idle(idle), .err(err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] key_mem [64];
    logic [7:0] cfg_mem [32];
    always @(posedge clk) begin
        bus.din      <= key_mem[bus.rd_addr];
        bus.cfg_data <= cfg_mem[bus.cfg_addr];
    end

    // scoreboard: {wr_en, ctrl, byte}
    logic [12:0] exp_q[$];
    logic [12:0] mon_got, mon_exp;
    int n_checks = 0, n_fail = 0;
    int wr_cnt = 0, ready_cnt = 0, ack_cnt = 0, first_cyc = 0, last_cyc = 0;

    always @(negedge clk) begin
        if (bus.word_ready) ready_cnt++;
        if (bus.bcast_ack) ack_cnt++;
        if (|bus.unit_in_wr_en) begin
            mon_got = {bus.unit_in_wr_en, bus.unit_in_ctrl, bus.unit_in};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got=%h required=none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_byte[%0d] got=%h required=%h", wr_cnt, mon_got, mon_exp);
                end
            end
            if (wr_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            wr_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    // expected packet from the framing rules, using the bench's own memory contents
    task automatic push_pkt(input int u, input logic [6:0] len, input logic [63:0] id);
        logic [3:0] oh;
        int kb;
        oh = 4'b0001 << u;
        exp_q.push_back({oh, 1'b1, 8'h00});
        for (int i = 0; i < CFGL; i++) exp_q.push_back({oh, 1'b0, cfg_mem[i]});
        for (int i = 0; i < 8; i++) exp_q.push_back({oh, 1'b0, id[i*8 +: 8]});
        exp_q.push_back({oh, 1'b0, 1'b0, len});
        for (int i = 0; i < 7; i++) exp_q.push_back({oh, 1'b0, 8'h00});
        kb = ((int'(len) + 3) / 4) * 4;
        for (int k = 0; k < kb; k++) exp_q.push_back({oh, (k == kb - 1), key_mem[k]});
    endtask

    // driver tasks (called just after a falling edge)
    task automatic clear_counts();
        wr_cnt = 0; ready_cnt = 0; ack_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.word_valid = 1'b0; bus.word_len = '0; bus.ids = '0;
        bus.unit_in_afull = '0; bus.unit_tx_mask = '0; bus.unit_done = '0;
        bus.bcast_req = 1'b0; bus.bcast_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_q.delete();
        clear_counts();
    endtask

    task automatic send_word(input logic [6:0] len, input logic [63:0] id);
        bit got;
        got = 1'b0;
        bus.word_len = len; bus.ids = id; bus.word_valid = 1'b1;
        for (int t = 0; t < 400 && !got; t++) begin
            @(negedge clk); #1;
            if (bus.word_ready) got = 1'b1;
        end
        bus.word_valid = 1'b0;
        chk("word_ready_seen", got, 1'b1);
    endtask

    task automatic pulse_done(input int u);
        bus.unit_done = 4'b0001 << u;
        @(negedge clk); #1;
        bus.unit_done = '0;
    endtask

    task automatic settle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic stall_cfg();
        int base;
        for (int t = 0; t < 300 && wr_cnt < 10; t++) begin @(negedge clk); #1; end
        chk("stall_start_reached", wr_cnt >= 10, 1'b1);
        bus.unit_in_afull = 4'hF;
        base = wr_cnt;
        settle(10);
        chk("afull_hold_no_write", wr_cnt, base);
        bus.unit_in_afull = '0;
    endtask

    typedef struct {
        logic [6:0]  len;
        logic [63:0] ids;
        bit          stall;
        int          exp_unit;
        int          exp_bytes;
    } vec_t;

    vec_t vecs[6];
    int base;

    initial begin
        vecs[0] = '{7'd5,  64'h0123_4567_89AB_CDEF, 1'b0, 0, 49};
        vecs[1] = '{7'd1,  64'hFEDC_BA98_7654_3210, 1'b0, 1, 45};
        vecs[2] = '{7'd4,  64'h1111_2222_3333_4444, 1'b0, 2, 45};
        vecs[3] = '{7'd64, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 3, 105};
        vecs[4] = '{7'd5,  64'h0123_4567_89AB_CDEF, 1'b1, 0, 49};
        vecs[5] = '{7'd13, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1, 57};
        for (int i = 0; i < 64; i++) key_mem[i] = 8'(8'h80 + i);
        for (int i = 0; i < 32; i++) cfg_mem[i] = 8'(8'h40 + 3 * i);

        do_reset();
        chk("rst_err", err, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_wr_en", bus.unit_in_wr_en, 4'h0);
        chk("rst_word_ready", bus.word_ready, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_addrs", {bus.rd_addr, bus.cfg_addr}, '0);

        // single-word packets, round-robin with credit return after each
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            push_pkt(vecs[i].exp_unit, vecs[i].len, vecs[i].ids);
            fork
                send_word(vecs[i].len, vecs[i].ids);
                begin if (vecs[i].stall) stall_cfg(); end
            join
            settle(3);
            chk("pkt_all_bytes_seen", exp_q.size(), 0);
            chk("pkt_byte_count", wr_cnt, vecs[i].exp_bytes);
            chk("pkt_span", last_cyc - first_cyc, vecs[i].exp_bytes - 1 + (vecs[i].stall ? 10 : 0));
            chk("pkt_ready_pulses", ready_cnt, 1);
            chk("pkt_not_idle_with_credit", idle, 1'b0);
            pulse_done(vecs[i].exp_unit);
            chk("pkt_err", err, 1'b0);
            chk("pkt_idle_after_done", idle, 1'b1);
        end

        // broadcast wins over a simultaneous word, then the word goes to unit 2
        clear_counts();
        exp_q.push_back({4'hF, 1'b1, 8'h19});
        push_pkt(2, 7'd5, 64'h0123_4567_89AB_CDEF);
        bus.bcast_data = 5'h03;
        bus.bcast_req = 1'b1;
        fork
            send_word(7'd5, 64'h0123_4567_89AB_CDEF);
            begin
                for (int t = 0; t < 50 && !bus.bcast_ack; t++) begin @(negedge clk); #1; end
                bus.bcast_req = 1'b0;
            end
        join
        settle(3);
        chk("bcast_all_bytes_seen", exp_q.size(), 0);
        chk("bcast_ack_pulses", ack_cnt, 1);
        chk("bcast_byte_count", wr_cnt, 50);
        pulse_done(2);

        // masked unit 1, one credit per unit: fourth word waits for unit 0
        do_reset();
        bus.unit_tx_mask = 4'b0010;
        push_pkt(0, 7'd8, 64'h0000_0000_0000_0001);
        send_word(7'd8, 64'h0000_0000_0000_0001);
        push_pkt(2, 7'd3, 64'h0000_0000_0000_0002);
        send_word(7'd3, 64'h0000_0000_0000_0002);
        push_pkt(3, 7'd7, 64'h0000_0000_0000_0003);
        send_word(7'd7, 64'h0000_0000_0000_0003);
        settle(2);
        chk("rr_three_pkts", exp_q.size(), 0);
        push_pkt(0, 7'd2, 64'h0000_0000_0000_0004);
        base = wr_cnt;
        fork
            send_word(7'd2, 64'h0000_0000_0000_0004);
            begin
                settle(30);
                chk("rr_wait_in_search", dbg_state, ST_SEARCH);
                chk("rr_wait_no_write", wr_cnt, base);
                chk("rr_wait_idle", idle, 1'b0);
                pulse_done(0);
            end
        join
        settle(3);
        chk("rr_fourth_to_unit0", exp_q.size(), 0);
        chk("rr_ready_pulses", ready_cnt, 4);
        pulse_done(0); pulse_done(2); pulse_done(3);
        chk("rr_idle_after_credits", idle, 1'b1);
        chk("rr_err", err, 1'b0);

        // credit return to a unit holding no credit
        do_reset();
        pulse_done(1);
        chk("done_zero_credit_err", err, 1'b1);
        chk("done_zero_credit_idle", idle, 1'b1);

        // zero-length and over-length words are discarded
        do_reset();
        send_word(7'd0, 64'h5);
        settle(3);
        chk("len0_err", err, 1'b1);
        chk("len0_ready_pulses", ready_cnt, 1);
        chk("len0_no_write", wr_cnt, 0);
        do_reset();
        send_word(7'd65, 64'h6);
        settle(3);
        chk("len65_err", err, 1'b1);
        chk("len65_no_write", wr_cnt, 0);
        chk("len65_state", dbg_state, ST_IDLE);

        // reset while streaming key bytes
        do_reset();
        push_pkt(0, 7'd64, 64'h7);
        bus.word_len = 7'd64; bus.ids = 64'h7; bus.word_valid = 1'b1;
        base = 0;
        for (int t = 0; t < 200 && dbg_state != ST_KEY; t++) begin @(negedge clk); #1; end
        chk("reach_key_state", dbg_state, ST_KEY);
        settle(3);
        bus.word_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_unit_in", {bus.unit_in, bus.unit_in_ctrl, bus.unit_in_wr_en}, '0);
        chk("midrst_ready_ack", {bus.word_ready, bus.bcast_ack}, '0);
        chk("midrst_addrs", {bus.rd_addr, bus.cfg_addr}, '0);
        chk("midrst_err", err, 1'b0);
        chk("midrst_idle", idle, 1'b1);
        chk("midrst_state", dbg_state, ST_IDLE);
        exp_q.delete();
        rst_n = 1'b1;
        base = wr_cnt;
        settle(5);
        chk("midrst_no_resume", wr_cnt, base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
